// File: rtl/weight_buffer_pkg.sv
// Shared types and constants for the weight buffer.
// No logic; constants only.
// No flow control; constants only.
package weight_buffer_pkg;

   // Default geometry, used as parameter defaults by the modules.
   localparam int DEF_DATA_W = 8;
   localparam int DEF_LANES  = 4;
   localparam int DEF_DEPTH  = 256;
   localparam int DEF_ROWS_W = 8;

   // One stored weight; DATA_W defaults to its width.
   typedef logic [DEF_DATA_W-1:0] weight_t;

   // Fetch addressing modes (cmd_transpose encoding).
   localparam logic MODE_ROW       = 1'b0;
   localparam logic MODE_TRANSPOSE = 1'b1;

   // Fetch engine states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FINISH = 2'd2
   } wb_state_e;

endpackage

// File: rtl/weight_ram.sv
// Weight storage: one write port, LANES synchronous read ports.
// Read latency 1 cycle; read data registers are the module outputs.
// rd_en low holds all read registers, which keeps the output row stable under stall.
module weight_ram
   import weight_buffer_pkg::*;
#(
   parameter int DATA_W = $bits(weight_t),
   parameter int LANES  = DEF_LANES,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rd_en,
   input  logic [LANES*ADDR_W-1:0] rd_addr,
   output logic [LANES*DATA_W-1:0] rd_data
);

   // Array contents are deliberately left unreset; software must write before fetching.
   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; a read of the same address on the same edge still sees the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read registers per lane, updated only when a new row is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         for (int i = 0; i < LANES; i++) begin
            rd_data[i*DATA_W +: DATA_W] <= mem[rd_addr[i*ADDR_W +: ADDR_W]];
         end
      end
   end

endmodule

// File: rtl/weight_buffer.sv
// Writable weight buffer with a command-driven row/transposed fetch engine.
// First row valid one cycle after command acceptance, then one row per cycle.
// Output row, out_last and the row counter hold while out_valid && !out_ready.
module weight_buffer
   import weight_buffer_pkg::*;
#(
   parameter int DATA_W = $bits(weight_t),
   parameter int LANES  = DEF_LANES,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int ROWS_W = DEF_ROWS_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_W-1:0]       cmd_base,
   input  logic [ROWS_W-1:0]       cmd_rows,
   input  logic [ADDR_W-1:0]       cmd_stride,
   input  logic                    cmd_transpose,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic                    out_last,
   output logic                    done,
   output logic                    busy
);

   wb_state_e state, state_nxt;

   // Command fields captured at acceptance so the source may change them afterwards.
   logic [ADDR_W-1:0]       lat_base;
   logic [ADDR_W-1:0]       lat_stride;
   logic [ROWS_W-1:0]       lat_rows;
   logic                    lat_transpose;

   // Index of the next row to issue; equals lat_rows once every row has been read.
   logic [ROWS_W-1:0]       row_cnt;

   logic                    issue;
   logic                    row_last;
   logic                    accept_last;
   logic                    cmd_take;
   logic [LANES*ADDR_W-1:0] rd_addr;

   assign cmd_take    = (state == IDLE) && cmd_valid;
   // A new row is read whenever rows remain and the output slot is free or draining.
   assign issue       = (state == STREAM) && (row_cnt != lat_rows) && (!out_valid || out_ready);
   assign row_last    = (row_cnt == lat_rows - ROWS_W'(1));
   assign accept_last = out_valid && out_ready && out_last;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: a zero-row command skips straight to the done pulse.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_nxt = (cmd_rows == '0) ? FINISH : STREAM;
            end
         end
         STREAM: begin
            if (accept_last) begin
               state_nxt = FINISH;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs; done lasts exactly the single FINISH cycle.
   always_comb begin
      cmd_ready = (state == IDLE);
      busy      = (state != IDLE);
      done      = (state == FINISH);
   end

   // Command capture and row counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_base      <= '0;
         lat_stride    <= '0;
         lat_rows      <= '0;
         lat_transpose <= MODE_ROW;
         row_cnt       <= '0;
      end else if (cmd_take) begin
         lat_base      <= cmd_base;
         lat_stride    <= cmd_stride;
         lat_rows      <= cmd_rows;
         lat_transpose <= cmd_transpose;
         row_cnt       <= '0;
      end else if (issue) begin
         row_cnt       <= row_cnt + ROWS_W'(1);
      end
   end

   // Output handshake flags travel alongside the RAM read registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (issue) begin
         out_valid <= 1'b1;
         out_last  <= row_last;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   // Per-lane read addresses; all arithmetic wraps modulo DEPTH by truncation.
   always_comb begin
      rd_addr = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lat_transpose == MODE_TRANSPOSE) begin
            rd_addr[i*ADDR_W +: ADDR_W] = lat_base + ADDR_W'(i) * lat_stride + ADDR_W'(row_cnt);
         end else begin
            rd_addr[i*ADDR_W +: ADDR_W] = lat_base + ADDR_W'(row_cnt) * ADDR_W'(LANES) + ADDR_W'(i);
         end
      end
   end

   weight_ram #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (issue),
      .rd_addr (rd_addr),
      .rd_data (out_data)
   );

endmodule

// File: tb/tb_weight_buffer.sv
// Self-checking bench for weight_buffer: directed table, timing sequences, random commands.
// Reference model is a plain memory array plus address arithmetic modulo DEPTH.
// Consumer backpressure is driven as fixed, patterned or random out_ready.
module tb_weight_buffer;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_base;
   logic [7:0]  cmd_rows;
   logic [7:0]  cmd_stride;
   logic        cmd_transpose;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        done;
   logic        busy;

   int errs = 0;
   int nchk = 0;

   logic [7:0] mdl [256];

   weight_buffer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_base      (cmd_base),
      .cmd_rows      (cmd_rows),
      .cmd_stride    (cmd_stride),
      .cmd_transpose (cmd_transpose),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .done          (done),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  base;
      logic [7:0]  rows;
      logic [7:0]  stride;
      logic        tr;
      int          rmode;
      bit          pre_wrap;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      mdl[a]  = d;
   endtask

   // Expected row from the model: lane i address by the mode's formula, modulo 256.
   function automatic logic [31:0] exp_row(input int b, input int s, input int t, input int r);
      logic [31:0] v;
      int a;
      v = '0;
      for (int i = 0; i < 4; i++) begin
         if (t != 0) a = (b + i * s + r) % 256;
         else        a = (b + r * 4 + i) % 256;
         v[i*8 +: 8] = mdl[a];
      end
      return v;
   endfunction

   // Issue one command, consume its rows under the chosen out_ready pattern, check all.
   task automatic run_cmd(input logic [7:0] b, input logic [7:0] n, input logic [7:0] s,
                          input logic t, input int rmode,
                          output logic [31:0] first, output logic [31:0] last);
      int got, dcnt, lastacc, post, limit, nn, w;
      logic        held_v, held_l;
      logic [31:0] held_d;
      nn = int'(n);
      cmd_base = b; cmd_rows = n; cmd_stride = s; cmd_transpose = t;
      cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 50) begin
         tick();
         w++;
      end
      chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
      tick();
      cmd_valid = 1'b0;
      got = 0; dcnt = 0; lastacc = -10; post = -1; held_v = 1'b0; held_l = 1'b0; held_d = '0;
      first = '0; last = '0;
      limit = nn * 20 + 40;
      for (int cyc = 0; cyc < limit; cyc++) begin
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (held_v) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {32'd0, out_data}, {32'd0, held_d});
            chk("hold_last", {63'd0, out_last}, {63'd0, held_l});
         end
         chk("done_valid_excl", {63'd0, done & out_valid}, 64'd0);
         if (done) begin
            dcnt++;
            if (dcnt == 1) begin
               if (nn > 0) chk("done_latency", 64'(cyc - lastacc), 64'd1);
               else        chk("done_latency0", 64'(cyc), 64'd0);
               post = cyc;
            end
         end
         held_v = out_valid && !out_ready;
         held_d = out_data;
         held_l = out_last;
         if (out_valid && out_ready) begin
            chk("row_data", {32'd0, out_data}, {32'd0, exp_row(int'(b), int'(s), int'(t), got)});
            chk("row_last", {63'd0, out_last}, {63'd0, got == nn - 1});
            if (got == 0) first = out_data;
            last = out_data;
            got++;
            lastacc = cyc;
         end
         if (post >= 0 && cyc >= post + 3) break;
         tick();
      end
      chk("row_count", 64'(got), 64'(nn));
      chk("done_count", 64'(dcnt), 64'd1);
      chk("idle_after", {63'd0, cmd_ready}, 64'd1);
      out_ready = 1'b1;
   endtask

   initial begin
      vec_t        vt [5];
      logic [31:0] f, l;
      int          w;

      vt[0] = '{8'h00, 8'd4, 8'd4, 1'b1, 0, 1'b0, 32'h0C080400, 32'h0F0B0703};
      vt[1] = '{8'h00, 8'd4, 8'd0, 1'b0, 1, 1'b0, 32'h03020100, 32'h0F0E0D0C};
      vt[2] = '{8'h01, 8'd3, 8'd3, 1'b1, 2, 1'b0, 32'h0A070401, 32'h0C090603};
      vt[3] = '{8'h05, 8'd0, 8'd0, 1'b0, 0, 1'b0, 32'h00000000, 32'h00000000};
      vt[4] = '{8'hFE, 8'd1, 8'd0, 1'b0, 0, 1'b1, 32'hA3A2A1A0, 32'hA3A2A1A0};

      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      cmd_valid = 1'b0; cmd_base = '0; cmd_rows = '0; cmd_stride = '0; cmd_transpose = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_out_last", {63'd0, out_last}, 64'd0);
      chk("rst_out_data", {32'd0, out_data}, 64'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_idle", {63'd0, cmd_ready}, 64'd1);

      // Define every word so fetches never read uninitialised storage
      for (int a = 0; a < 256; a++) wr(8'(a), 8'($urandom));

      // Single row: exact latency of row, done and cmd_ready return
      wr(8'h0F, 8'd3); wr(8'h10, 8'd5); wr(8'h11, 8'd4); wr(8'h12, 8'd6);
      cmd_base = 8'h0F; cmd_rows = 8'd1; cmd_stride = '0; cmd_transpose = 1'b0;
      cmd_valid = 1'b1; out_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("t1_accept_valid", {63'd0, out_valid}, 64'd0);
      chk("t1_accept_ready", {63'd0, cmd_ready}, 64'd0);
      chk("t1_accept_busy", {63'd0, busy}, 64'd1);
      tick();
      chk("t1_row_valid", {63'd0, out_valid}, 64'd1);
      chk("t1_row_data", {32'd0, out_data}, 64'h06040503);
      chk("t1_row_last", {63'd0, out_last}, 64'd1);
      chk("t1_row_done", {63'd0, done}, 64'd0);
      tick();
      chk("t1_done", {63'd0, done}, 64'd1);
      chk("t1_done_valid", {63'd0, out_valid}, 64'd0);
      chk("t1_done_ready", {63'd0, cmd_ready}, 64'd0);
      tick();
      chk("t1_done_clear", {63'd0, done}, 64'd0);
      chk("t1_ready_back", {63'd0, cmd_ready}, 64'd1);
      chk("t1_busy_clear", {63'd0, busy}, 64'd0);

      // Directed command table
      for (int a = 0; a < 16; a++) wr(8'(a), 8'(a));
      for (int k = 0; k < 5; k++) begin
         if (vt[k].pre_wrap) begin
            wr(8'hFE, 8'hA0); wr(8'hFF, 8'hA1); wr(8'h00, 8'hA2); wr(8'h01, 8'hA3);
         end
         run_cmd(vt[k].base, vt[k].rows, vt[k].stride, vt[k].tr, vt[k].rmode, f, l);
         if (vt[k].rows != 0) begin
            chk($sformatf("vec%0d_first", k), {32'd0, f}, {32'd0, vt[k].exp_first});
            chk($sformatf("vec%0d_last", k), {32'd0, l}, {32'd0, vt[k].exp_last});
         end
      end

      // Writes during a stream: unfetched address is seen, same-edge read sees old data
      wr(8'h00, 8'h00); wr(8'h01, 8'h01);
      cmd_base = 8'h00; cmd_rows = 8'd4; cmd_stride = '0; cmd_transpose = 1'b0;
      cmd_valid = 1'b1; out_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 8'd13; wr_data = 8'h77;
      tick();
      chk("ws_row0", {32'd0, out_data}, 64'h03020100);
      wr_addr = 8'd4; wr_data = 8'h55;
      tick();
      wr_en = 1'b0;
      chk("ws_row1_old", {32'd0, out_data}, 64'h07060504);
      tick();
      chk("ws_row2", {32'd0, out_data}, 64'h0B0A0908);
      tick();
      chk("ws_row3_new", {32'd0, out_data}, 64'h0F0E770C);
      chk("ws_row3_last", {63'd0, out_last}, 64'd1);
      mdl[13] = 8'h77;
      mdl[4]  = 8'h55;
      tick();
      chk("ws_done", {63'd0, done}, 64'd1);
      tick();
      chk("ws_idle", {63'd0, cmd_ready}, 64'd1);

      // Reset in the middle of a four-row command
      cmd_base = 8'h00; cmd_rows = 8'd4; cmd_stride = '0; cmd_transpose = 1'b0;
      cmd_valid = 1'b1; out_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("mr_row0", {32'd0, out_data}, {32'd0, exp_row(0, 0, 0, 0)});
      tick();
      chk("mr_row1", {32'd0, out_data}, {32'd0, exp_row(0, 0, 0, 1)});
      tick();
      chk("mr_row2_valid", {63'd0, out_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_valid_drop", {63'd0, out_valid}, 64'd0);
      chk("mr_busy_drop", {63'd0, busy}, 64'd0);
      chk("mr_done_low", {63'd0, done}, 64'd0);
      chk("mr_data_zero", {32'd0, out_data}, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      w = 0;
      for (int c = 0; c < 4; c++) begin
         if (done) w++;
         tick();
      end
      chk("mr_no_done", 64'(w), 64'd0);
      run_cmd(8'h00, 8'd4, 8'h00, 1'b0, 0, f, l);

      // Random commands under random backpressure against the model
      for (int it = 0; it < 30; it++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int j = 0; j < nw; j++) wr(8'($urandom), 8'($urandom));
         run_cmd(8'($urandom), 8'($urandom_range(0, 12)), 8'($urandom),
                 1'($urandom_range(0, 1)), 2, f, l);
      end

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule

// File: doc/weight_buffer.md
Name: weight_buffer

Overview:
Parametrised weight store for the systolic array. It supersedes the fixed 4-word combinational weight ROM with a writable, power-of-two-deep buffer and a command-driven fetch engine. The engine streams LANES-wide weight rows to the array under valid/ready flow control. Each command reads either row-major or transposed (strided) data, so the host writes weights row-wise and the buffer handles the transposition.

Parameters:
DATA_W, 8, bits per weight
LANES, 4, weights per output row (array width)
DEPTH, 256, words in buffer; must be a power of two
ADDR_W, $clog2(DEPTH), address width
ROWS_W, 8, width of row-count field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe, one word per cycle
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
cmd_valid  in  1  fetch command valid
cmd_ready  out  1  engine idle, accepts command
cmd_base  in  ADDR_W  start address
cmd_rows  in  ROWS_W  rows to emit
cmd_stride  in  ADDR_W  lane stride, transposed mode only
cmd_transpose  in  1  0 = row-major, 1 = transposed
out_valid  out  1  out_data holds a row
out_ready  in  1  consumer accepts row
out_data  out  LANES*DATA_W  lane i in bits [i*DATA_W +: DATA_W]
out_last  out  1  marks final row of command
done  out  1  one-cycle pulse after final row is accepted
busy  out  1  command in progress

Behaviour:
- Reset: asynchronous on rst_n low.
  - Clears: FSM to IDLE, row counter, out_valid, out_last, done, busy, and all latched command fields.
  - out_data resets to 0.
  - Memory contents are not reset; they are undefined until written.
- FSM states: IDLE, STREAM, FINISH.
  - IDLE: cmd_ready=1. On cmd_valid, latch base/rows/stride/transpose and set r=0.
    - If rows==0, go to FINISH.
    - Otherwise go to STREAM.
  - STREAM: each cycle with (!out_valid || out_ready), read row r into the output register. Set out_valid=1 and out_last=(r==rows-1), then r++.
    - After the last row is issued, wait until it is accepted (out_valid && out_ready with out_last), then go to FINISH.
  - FINISH: assert done for exactly one cycle, then go to IDLE.
- busy=1 in STREAM and FINISH. cmd_ready=0 outside IDLE.
- Addressing for lane i of row r:
  - Row-major: base + r*LANES + i.
  - Transposed: base + i*stride + r.
  - All sums are truncated to ADDR_W bits, so addresses wrap modulo DEPTH with no error.
- Read is synchronous; the memory read data is the output register.
  - Command accepted at edge T: first row valid after edge T+1.
  - Throughput is 1 row/cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable and r does not advance.
- Write port is independent and may be active in any state, including STREAM.
- Same-edge write and read of one address: the read returns the OLD data (read-before-write). The new data is visible from the next read.
- Writes to addresses not yet fetched in the current command are seen by that command.
- cmd_valid while not IDLE is ignored; the source must hold it until cmd_ready.
- done and out_valid are never asserted in the same cycle.
- rst_n low mid-command aborts it: no done pulse, out_valid drops immediately.

Decomposition:
- Package weight_buffer_pkg holds:
  - wb_state_e enum {IDLE, STREAM, FINISH}
  - typedef weight_t = logic [DATA_W-1:0], exported through parameter defaults
  - localparam MODE_ROW=0 and MODE_TRANSPOSE=1
- Sub-module weight_ram: DEPTH x DATA_W array with one write port and LANES synchronous read ports.
  - It has a read-enable that gates read-register update for backpressure hold.
  - It has no reset on the array.
- Address generation, row counter and FSM live in weight_buffer.

Test Plan:
- Write 3,5,4,6 to 0x0F..0x12, then cmd base=0x0F rows=1 row-major with out_ready=1 -> one cycle after acceptance: out_data lanes {3,5,4,6}, out_last=1. done pulses the cycle after the row is accepted; cmd_ready returns the next cycle.
- Write 0..15 to addr 0..15, then cmd base=0 rows=4 transpose stride=4 -> rows {0,4,8,12},{1,5,9,13},{2,6,10,14},{3,7,11,15} on consecutive cycles, out_last only on the 4th.
- Same data, rows=4 row-major, out_ready toggling 1,0,0,1,... -> rows {0,1,2,3}..{12,13,14,15} in order, no row dropped or duplicated, out_data stable while stalled.
- DEPTH=256, write 0xA0..0xA3 to 0xFE,0xFF,0x00,0x01, then cmd base=0xFE rows=1 -> lanes {0xA0,0xA1,0xA2,0xA3} (wrap).
- cmd rows=0 -> no out_valid, done pulses once, back to IDLE.
- Assert rst_n low during row 2 of a 4-row command -> out_valid, busy and done go to 0 at once and no done pulse follows. A new command after release streams correctly and memory data is retained.
